// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CHANNELS  = 4;
  localparam int DUTY_BUS_MAX  = 1024;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Extracts channel idx's duty from a packed bus zero-extended to DUTY_BUS_MAX bits.
  function automatic logic [31:0] chan_duty(input logic [DUTY_BUS_MAX-1:0] bus,
                                            input int idx, input int width);
    logic [DUTY_BUS_MAX-1:0] sh;
    sh = bus >> (idx * width);
    return sh[31:0] & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: compares the shared count with its duty and registers the level.
module pwm_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  input  logic             polarity,
  output logic             pwm_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= 1'b0;
    end else if (!en) begin
      pwm_out <= polarity;
    end else begin
      pwm_out <= (cnt < duty) ^ polarity;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter (edge or centre aligned), shadowed
// period/duty/mode registers that transfer at period boundaries, per-channel outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       polarity,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      load_pending
);

  logic [WIDTH-1:0]          cnt;
  dir_e                      dir;
  logic [WIDTH-1:0]          per_a, per_p;
  logic [CHANNELS*WIDTH-1:0] duty_a, duty_p;
  logic                      mode_a, mode_p;
  logic [WIDTH-1:0]          p_eff, p_last;
  logic                      boundary, xfer;
  logic                      fresh;

  always_comb begin
    p_eff    = (per_a == '0) ? WIDTH'(1) : per_a;
    p_last   = p_eff - WIDTH'(1);
    boundary = 1'b0;
    if (en) begin
      if (mode_a == MODE_EDGE) boundary = (cnt == p_last);
      else                     boundary = (cnt == '0) && (dir == DIR_DOWN);
    end
    xfer = !en || boundary;
  end

  // A load landing on a transfer edge bypasses the pending stage entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_a        <= '0;
      duty_a       <= '0;
      mode_a       <= MODE_EDGE;
      per_p        <= '0;
      duty_p       <= '0;
      mode_p       <= MODE_EDGE;
      load_pending <= 1'b0;
    end else if (load && xfer) begin
      per_a        <= period;
      duty_a       <= duty;
      mode_a       <= mode;
      per_p        <= period;
      duty_p       <= duty;
      mode_p       <= mode;
      load_pending <= 1'b0;
    end else if (load) begin
      per_p        <= period;
      duty_p       <= duty;
      mode_p       <= mode;
      load_pending <= 1'b1;
    end else if (xfer && load_pending) begin
      per_a        <= per_p;
      duty_a       <= duty_p;
      mode_a       <= mode_p;
      load_pending <= 1'b0;
    end
  end

  // Centre mode holds each endpoint for two cycles by turning around in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (!en || boundary) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (mode_a == MODE_EDGE) begin
      cnt <= cnt + WIDTH'(1);
      dir <= DIR_UP;
    end else if (dir == DIR_UP) begin
      if (cnt == p_last) dir <= DIR_DOWN;
      else               cnt <= cnt + WIDTH'(1);
    end else begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  // fresh marks a cycle holding count 0 of a new period; its pulse lines up with that count's output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fresh        <= 1'b1;
      period_start <= 1'b0;
    end else begin
      fresh        <= xfer;
      period_start <= en && fresh;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] duty_ch;
    assign duty_ch = WIDTH'(chan_duty(DUTY_BUS_MAX'(duty_a), i, WIDTH));

    pwm_chan #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .cnt      (cnt),
      .duty     (duty_ch),
      .polarity (polarity[i]),
      .pwm_out  (pwm_out[i])
    );
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator, the next generation of the single-channel 8-bit pwm block. It has one shared period counter and CHANNELS independent duty comparators. It adds a programmable period, edge- or centre-aligned mode, per-channel polarity, and glitch-free shadow-register updates at period boundaries. It sits in the peripheral fabric and drives motor/LED/DAC-filter outputs from a register interface.

Parameters:
WIDTH, 8, bit width of the counter, period and each duty value
CHANNELS, 4, number of PWM outputs sharing the counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  run enable; low holds the counter and forces outputs inactive
load  in  1  single-cycle strobe; captures period, duty, mode into the pending registers
period  in  WIDTH  counts per period (P)
duty  in  CHANNELS*WIDTH  packed duty values; channel i is duty[i*WIDTH +: WIDTH]
mode  in  1  0 = edge-aligned, 1 = centre-aligned
polarity  in  CHANNELS  per-channel inversion; 1 = active-low output
pwm_out  out  CHANNELS  registered PWM outputs
period_start  out  1  one-cycle pulse, registered, when the counter starts a new period
load_pending  out  1  high while pending values await transfer

Behaviour:
- Reset (async, rst=1):
  - counter=0, direction=up.
  - active and pending period/duty/mode all 0.
  - pwm_out=0, period_start=0, load_pending=0.
- load=1: on that edge, period/duty/mode go into the pending registers and load_pending is set. A second load before transfer overwrites the pending values.
- Transfer pending to active:
  - occurs at a boundary edge, or on any edge while en=0;
  - clears load_pending;
  - the new values govern from count 0 of the following period.
- load coincident with a transfer edge: the inputs on the load cycle go straight to active, and load_pending stays 0.
- Effective P = max(active period, 1).
- Edge mode:
  - counter 0,1,…,P-1, wrap to 0; period = P cycles.
  - boundary is the cycle with cnt==P-1.
- Centre mode:
  - counter up 0…P-1, then down P-1…0 (each endpoint held two cycles); period = 2P cycles.
  - boundary is the cycle with cnt==0 and direction=down.
  - direction resets to up on wrap and on a mode change at transfer.
- Channel raw level = (cnt < duty_active[i]).
  - duty=0 gives always low; duty>=P gives always high, with no single-cycle glitch.
  - Centre-mode high time = 2*min(duty,P) cycles, contiguous across the wrap.
- pwm_out[i] = raw ^ polarity[i], registered: one cycle of latency from counter value to output.
- period_start = 1 for one cycle, one cycle after the counter leaves the boundary (aligned with the output of count 0).
- en=0:
  - counter held at 0, direction=up.
  - pwm_out = polarity (inactive level) from the next edge.
  - period_start=0.
- en rising: counting starts at 0 on the next edge; the first period is complete.
- Counter arithmetic is WIDTH bits. P-1 never underflows because P>=1. period=2^WIDTH-1 is the maximum.
- polarity is not shadowed; it applies on the next edge.

Decomposition:
- Package pwm_pkg holds:
  - mode constants MODE_EDGE=1'b0 and MODE_CENTER=1'b1;
  - the default WIDTH and CHANNELS;
  - a function extracting channel i's duty from the packed bus.
- Natural sub-module pwm_chan: one per channel via generate. It takes cnt, duty_active[i] and polarity[i], and produces the registered output bit.
- Top level holds the counter, direction, shadow registers and boundary logic.

Test Plan:
1. Edge mode, P=10, duty0=3, polarity=0, en=1 after load → pwm_out[0] repeats 3 high / 7 low; period_start every 10 cycles, coincident with the output going high.
2. Boundaries, P=10, duty0=0, duty1=10, duty2=255 → ch0 constantly 0, ch1 and ch2 constantly 1 over 5 periods, no glitch at wrap.
3. Centre mode, P=4, duty0=2 → counter 0,1,2,3,3,2,1,0; pwm_out[0] high 4 of 8 cycles, contiguous across the wrap; period_start every 8 cycles.
4. Shadow update: run P=10, duty0=3, then load duty0=7 at count 4 → load_pending=1 until the boundary; the current period stays at 3 high, the next shows 7 high; load_pending clears at the boundary.
5. Polarity and enable: polarity=4'b0101, en=0 → pwm_out=4'b0101 held; en=1 → channels 0 and 2 toggle inverted with the same duty timing.
6. Reset mid-period at count 5 → all outputs, period_start and load_pending go 0 immediately (async); after release, active duty=0, so outputs stay at polarity-inactive until a new load.
